// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 state encoding, command constants and parity helper shared by host TX and receiver
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, INHIBIT, SHIFT, WAIT_IDLE} state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer, FILTER_LEN glitch filter and falling-edge pulse for one PS/2 pin
module ps2_line_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A new level is taken only after FILTER_LEN consecutive samples disagree with the current one
    always_comb begin
        cnt_d  = '0;
        lvl_d  = lvl_q;
        fall_d = 1'b0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                lvl_d  = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            lvl_q  <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= pin;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = lvl_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter; request-to-send, frame shift on device clock, ACK check.
module ps2_host_tx import ps2_pkg::*; #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int DATA_LEAD      = 200,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q, state_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    n_q, n_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic          ack_ok_q, ack_ok_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          terr_q, terr_d;

    logic          kclk, kdata, kclk_fall, unused_kdata_fall;
    logic          accept, in_frame, lines_idle, timeout, last_fall;
    logic [2:0]    bit_idx;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
        .clk(clk), .rst_n(rst_n), .pin(kclk_in), .level(kclk), .fall(kclk_fall)
    );

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_data_sync (
        .clk(clk), .rst_n(rst_n), .pin(kdata_in), .level(kdata), .fall(unused_kdata_fall)
    );

    assign accept     = state_q == IDLE && tx_valid;
    assign in_frame   = state_q == SHIFT || state_q == WAIT_IDLE;
    assign lines_idle = kclk && kdata;
    assign timeout    = !kclk_fall && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
    assign last_fall  = state_q == SHIFT && kclk_fall && n_q == 4'd10;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            icnt_q    <= '0;
            tcnt_q    <= '0;
            n_q       <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            ack_ok_q  <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            icnt_q    <= icnt_d;
            tcnt_q    <= tcnt_d;
            n_q       <= n_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
            ack_ok_q  <= ack_ok_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            terr_q    <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      state_d = tx_valid ? INHIBIT : IDLE;
            INHIBIT:   state_d = (icnt_q == IW'(INHIBIT_CYCLES - 1)) ? SHIFT : INHIBIT;
            SHIFT:     state_d = last_fall ? WAIT_IDLE : timeout ? IDLE : SHIFT;
            WAIT_IDLE: state_d = (lines_idle || timeout) ? IDLE : WAIT_IDLE;
        endcase
    end

    // Falls seen during INHIBIT are the device finishing its own frame and are deliberately ignored
    always_comb begin
        icnt_d    = (state_q == INHIBIT) ? icnt_q + 1'b1 : '0;
        tcnt_d    = (in_frame && !kclk_fall) ? tcnt_q + 1'b1 : '0;
        n_d       = (state_q != SHIFT) ? '0 : kclk_fall ? n_q + 1'b1 : n_q;
        sh_d      = accept ? tx_data : sh_q;
        par_d     = accept ? odd_parity(tx_data) : par_q;
        ack_ok_d  = last_fall ? ~kdata : ack_ok_q;
        done_d    = state_q == WAIT_IDLE && lines_idle;
        ack_err_d = done_d && !ack_ok_q;
        terr_d    = in_frame && timeout && !done_d;
    end

    always_comb begin
        bit_idx  = 3'(n_q - 4'd1);
        kclk_oe  = state_q == INHIBIT;
        kdata_oe = 1'b0;
        if (state_q == INHIBIT)
            kdata_oe = icnt_q >= IW'(INHIBIT_CYCLES - DATA_LEAD);
        else if (state_q == SHIFT)
            kdata_oe = (n_q == 4'd0) ? 1'b1 :
                       (n_q <= 4'd8) ? ~sh_q[bit_idx] :
                       (n_q == 4'd9) ? ~par_q : 1'b0;
    end

    assign tx_ready    = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench with a behavioural PS/2 device model and frame reference model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 100;
    localparam int LEAD = 10;
    localparam int TO   = 5000;
    localparam int H    = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, kclk_oe, kdata_oe, busy, done, ack_err, timeout_err;
    logic       dclk = 1'b0;
    logic       ddat = 1'b0;
    wire        kclk_in  = !(kclk_oe || dclk);
    wire        kdata_in = !(kdata_oe || ddat);
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH), .DATA_LEAD(LEAD), .TIMEOUT_CYCLES(TO), .FILTER_LEN(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .kclk_in(kclk_in), .kdata_in(kdata_in), .kclk_oe(kclk_oe), .kdata_oe(kdata_oe),
        .busy(busy), .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wire order: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic p;
        p = ($countones(b) % 2) == 0;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic wait_request(output bit seen);
        int w = 0;
        while (!(!kclk_oe && kdata_oe) && w < 400) begin
            @(negedge clk);
            w++;
        end
        seen = w < 400;
    endtask

    task automatic dev_frame(input bit ack, output logic [10:0] bits, output bit seen);
        bits = '0;
        wait_request(seen);
        if (!seen) return;
        repeat (20) @(negedge clk);
        bits[0] = kdata_in;
        for (int k = 1; k <= 11; k++) begin
            dclk = 1'b1;
            repeat (H) @(negedge clk);
            dclk = 1'b0;
            if (k == 11) ddat = 1'b0;
            @(negedge clk);
            if (k <= 10) bits[k] = kdata_in;
            repeat (H / 2 - 1) @(negedge clk);
            if (k == 10 && ack) ddat = 1'b1;
            repeat (H / 2) @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input bit hold, input string tag);
        logic [10:0] bits;
        bit          seen;
        bit          got_done = 1'b0;
        logic        got_err = 1'b0;
        logic        done_after = 1'b1;
        int          bad = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        fork
            dev_frame(ack, bits, seen);
            begin
                for (int c = 0; c < 3000 && !got_done; c++) begin
                    @(negedge clk);
                    if (hold) tx_data = 8'($urandom);
                    else tx_valid = 1'b0;
                    if (done) begin
                        got_done = 1'b1;
                        got_err  = ack_err;
                        if (busy || !tx_ready) bad++;
                        tx_valid = 1'b0;
                    end else if (tx_ready || !busy) begin
                        bad++;
                    end
                end
                tx_valid = 1'b0;
                if (got_done) begin
                    @(negedge clk);
                    done_after = done;
                end
            end
        join
        check({tag, "_request"}, 32'(seen), 1);
        check({tag, "_frame"}, 32'(bits), 32'(frame_of(b)));
        check({tag, "_done"}, 32'(got_done), 1);
        check({tag, "_ack_err"}, 32'(got_err), 32'(!ack));
        check({tag, "_ready_busy"}, bad, 0);
        check({tag, "_done_pulse"}, 32'(done_after), 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic timeout_test();
        int  hi = 0, lead = 0, c = 0, t = 0;
        bit  saw_done = 1'b0;
        @(negedge clk);
        tx_data  = CMD_SET_LEDS;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        while (kclk_oe && c < 1000) begin
            hi++;
            if (kdata_oe) lead++;
            @(negedge clk);
            c++;
        end
        check("inhibit_len", hi, INH);
        check("data_lead", lead, LEAD);
        check("start_held", 32'(kdata_oe), 1);
        while (!timeout_err && t < TO + 1000) begin
            @(negedge clk);
            t++;
            if (done) saw_done = 1'b1;
        end
        check("timeout_cycles", t, TO);
        check("timeout_release", 32'({kclk_oe, kdata_oe, busy}), 0);
        check("timeout_no_done", 32'(saw_done), 0);
        @(negedge clk);
        check("timeout_pulse", 32'(timeout_err), 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic reset_test();
        logic [7:0] b;
        bit         seen;
        b = 8'($urandom);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_request(seen);
        check("rst_request", 32'(seen), 1);
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            dclk = 1'b1;
            repeat (H) @(negedge clk);
            if (k < 4) begin
                dclk = 1'b0;
                repeat (H) @(negedge clk);
            end
        end
        check("rst_bit3_drive", 32'(kdata_oe), 32'(!b[3]));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_release", 32'({kclk_oe, kdata_oe, busy, tx_ready}), 32'b0001);
        dclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit         ack;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({kclk_oe, kdata_oe, tx_ready, busy, done, ack_err, timeout_err}),
              32'b0010000);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_frame(CMD_SET_LEDS, 1'b1, 1'b0, "set_leds");
        run_frame(8'h00, 1'b0, 1'b0, "zero_nak");
        timeout_test();
        run_frame(8'($urandom), 1'b1, 1'b1, "hold_valid");
        for (int i = 0; i < 4; i++) begin
            b   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            run_frame(b, ack, 1'b0, "random");
        end
        reset_test();
        run_frame(CMD_RESET, 1'b1, 1'b0, "after_reset");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
